maxpool2x2_stream: RTL and testbench

Streaming 2x2, stride-2 max-pooling engine with its own sequencing controller. It sits directly after a convolution channel output. It takes one feature-map pixel per valid_in in row-major order and emits one pooled pixel per 2x2 window. Row and column counters, pair/row phase tracking and a half-width line buffer let a full frame be pooled without backpressure or host sequencing.

---
 rtl/maxpool2x2_stream.sv | 155 +++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 125 ++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 signed max pooling.
// Pixels arrive in row-major order, one per valid_in. Even rows reduce
// horizontal pairs into a half-width line buffer. Odd rows combine their
// own pair maximum with the stored value and emit one pooled pixel.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   clear           synchronous frame abort (counters/phase to frame start)
//   valid_in        data_in carries a pixel this cycle (no backpressure)
//   data_in         signed input pixel
//   valid_out       one-cycle pulse: data_out holds a new pooled pixel
//   data_out        registered pooled pixel; holds between pulses
//   frame_done      pulses with valid_out of the frame's last window
module maxpool2x2_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_WIDTH  = 24,
  parameter int unsigned IMG_HEIGHT = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  // Frame geometry must be even in both dimensions
  if ((IMG_WIDTH < 2) || ((IMG_WIDTH % 2) != 0)) begin : g_bad_width
    $error("maxpool2x2_stream: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT < 2) || ((IMG_HEIGHT % 2) != 0)) begin : g_bad_height
    $error("maxpool2x2_stream: IMG_HEIGHT must be even and >= 2");
  end

  localparam int unsigned COL_W  = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned HALF_W = IMG_WIDTH / 2;
  localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    EVEN_FIRST  = 2'd0,
    EVEN_SECOND = 2'd1,
    ODD_FIRST   = 2'd2,
    ODD_SECOND  = 2'd3
  } phase_e;

  phase_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  frame_done_q, frame_done_d;

  // Half-width line buffer; every entry is written on an even row before
  // the following odd row reads it, so it needs no reset.
  logic [DATA_WIDTH-1:0] line_buf_q [HALF_W];
  logic                  lb_we;
  logic [IDX_W-1:0]      lb_idx;

  logic signed [DATA_WIDTH-1:0] pix_s, pair_s, lb_s, hmax, result;
  logic                         col_last, row_last;

  assign col_last = (col_q == COL_MAX);
  assign row_last = (row_q == ROW_MAX);
  assign lb_idx   = IDX_W'(col_q >> 1);

  // Signed datapath: horizontal pair max, then vertical max with stored row
  assign pix_s  = $signed(data_in);
  assign pair_s = $signed(pair_q);
  assign lb_s   = $signed(line_buf_q[lb_idx]);
  assign hmax   = (pix_s > pair_s) ? pix_s : pair_s;
  assign result = (lb_s > hmax) ? lb_s : hmax;

  // Next-state: counters, phase, pair register and output registers
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    data_out_d   = data_out_q;
    lb_we        = 1'b0;
    if (clear) begin
      col_d   = '0;
      row_d   = '0;
      state_d = EVEN_FIRST;
    end else if (valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      case (state_q)
        EVEN_FIRST: begin
          pair_d  = data_in;
          state_d = EVEN_SECOND;
        end
        EVEN_SECOND: begin
          lb_we   = 1'b1;
          state_d = col_last ? ODD_FIRST : EVEN_FIRST;
        end
        ODD_FIRST: begin
          pair_d  = data_in;
          state_d = ODD_SECOND;
        end
        ODD_SECOND: begin
          data_out_d   = result;
          valid_out_d  = 1'b1;
          frame_done_d = row_last && col_last;
          state_d      = col_last ? EVEN_FIRST : ODD_FIRST;
        end
        default: state_d = EVEN_FIRST;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EVEN_FIRST;
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer write port
  always_ff @(posedge clk) begin
    if (!rst && lb_we) begin
      line_buf_q[lb_idx] <= hmax;
    end
  end

  assign valid_out  = valid_out_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x4 instance (ramp, gaps, clear,
// back-to-back frames) and a 4x2 instance (signed comparison).
module tb_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        vin_a, vin_b;
  logic [15:0] din_a, din_b;
  logic        vout_a, vout_b, done_a, done_b;
  logic [15:0] dout_a, dout_b;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_a, exp_b;

  always #5 clk = ~clk;

  maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .valid_in(vin_a), .data_in(din_a),
    .valid_out(vout_a), .data_out(dout_a), .frame_done(done_a)
  );

  maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .valid_in(vin_b), .data_in(din_b),
    .valid_out(vout_b), .data_out(dout_b), .frame_done(done_b)
  );

  task automatic check(input string tag, input string what,
                       input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // One clock: drive one DUT (sel=0 -> 4x4, sel=1 -> 4x2), then check it
  task automatic step(input bit sel, input bit v, input logic [15:0] d,
                      input bit c, input bit ev, input logic [15:0] ed,
                      input bit ef, input string tag);
    if (sel) begin
      vin_b = v; din_b = d; vin_a = 1'b0;
    end else begin
      vin_a = v; din_a = d; vin_b = 1'b0;
    end
    clear = c;
    @(posedge clk); #1;
    vin_a = 1'b0; vin_b = 1'b0; clear = 1'b0;
    if (sel) begin
      if (ev) exp_b = ed;
      check(tag, "valid_out", 16'(vout_b), 16'(ev));
      check(tag, "frame_done", 16'(done_b), 16'(ef));
      check(tag, "data_out", dout_b, exp_b);
    end else begin
      if (ev) exp_a = ed;
      check(tag, "valid_out", 16'(vout_a), 16'(ev));
      check(tag, "frame_done", 16'(done_a), 16'(ef));
      check(tag, "data_out", dout_a, exp_a);
    end
  endtask

  // 4x4 ramp off..off+15; windows complete on pixels 5, 7, 13, 15
  task automatic ramp(input int off, input bit gaps, input string tag);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(3));
        for (int k = 0; k < g; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, {tag, "_idle"});
      end
      step(1'b0, 1'b1, 16'(i + off), 1'b0,
           (i == 5) || (i == 7) || (i == 13) || (i == 15),
           16'(i + off), i == 15, tag);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    vin_a = 1'b0; vin_b = 1'b0; din_a = 16'h0; din_b = 16'h0;

    // Reset held 3 cycles with valid_in toggling
    for (int i = 0; i < 3; i++) begin
      vin_a = i[0]; din_a = 16'h0055; vin_b = ~i[0]; din_b = 16'h0077;
      @(posedge clk); #1;
      check("reset", "valid_out", 16'(vout_a), 16'h0);
      check("reset", "data_out", dout_a, 16'h0);
      check("reset", "frame_done", 16'(done_a), 16'h0);
      check("reset_b", "data_out", dout_b, 16'h0);
    end
    rst = 1'b0; vin_a = 1'b0; vin_b = 1'b0;
    exp_a = 16'h0; exp_b = 16'h0;

    // Ramp frame: first post-reset pixel is (0,0)
    ramp(0, 1'b0, "ramp");

    // Signed max on the 4x2 instance: outputs -1 then -2
    step(1'b1, 1'b1, 16'(-3), 1'b0, 1'b0, 16'h0, 1'b0, "signed");
    step(1'b1, 1'b1, 16'(-1), 1'b0, 1'b0, 16'h0, 1'b0, "signed");
    step(1'b1, 1'b1, 16'(-8), 1'b0, 1'b0, 16'h0, 1'b0, "signed");
    step(1'b1, 1'b1, 16'(-2), 1'b0, 1'b0, 16'h0, 1'b0, "signed");
    step(1'b1, 1'b1, 16'(-5), 1'b0, 1'b0, 16'h0, 1'b0, "signed");
    step(1'b1, 1'b1, 16'(-4), 1'b0, 1'b1, 16'(-1), 1'b0, "signed");
    step(1'b1, 1'b1, 16'(-7), 1'b0, 1'b0, 16'h0, 1'b0, "signed");
    step(1'b1, 1'b1, 16'(-6), 1'b0, 1'b1, 16'(-2), 1'b1, "signed");
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, "signed_tail");

    // Gapped ramp: same outputs, each one cycle after its 4th pixel
    ramp(0, 1'b1, "gapped");

    // Clear mid-frame: pixels 0..9, then clear with pixel 10 (dropped)
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 16'(i), 1'b0, (i == 5) || (i == 7), 16'(i), 1'b0, "pre_clear");
    step(1'b0, 1'b1, 16'd10, 1'b1, 1'b0, 16'h0, 1'b0, "clear");
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, "post_clear");
    ramp(0, 1'b0, "after_clear");

    // Back-to-back frames with no idle cycle between them
    ramp(0, 1'b0, "b2b_f0");
    ramp(100, 1'b0, "b2b_f1");
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, "b2b_tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
